// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with valid/ready handshake.
// A main entry plus a one-deep skid entry keep In_Ready a pure flop output,
// so downstream back-pressure never reaches upstream combinationally.
// Control payload is squashed to zero on bubbles, flush and reset; the data
// payload only loads on capture and is left untouched by flush.
// Optional build macro: PIPE_STAGE_STATS_EN enables saturating stall/bubble
// counters; without it Stall_Cnt/Bubble_Cnt are tied to zero.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 224,
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] Ctrl_In,
  input  logic [DATA_W-1:0] Data_In,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Ctrl_Out,
  output logic [DATA_W-1:0] Data_Out,
  output logic [CNT_W-1:0]  Stall_Cnt,
  output logic [CNT_W-1:0]  Bubble_Cnt
);

  // Encoding is {main valid, skid valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic                m_v, s_v;
  logic                in_xfer, out_xfer;
  logic                m_load_in, m_load_skid, s_load_in;
  logic [CTRL_W-1:0]   m_ctrl_q, s_ctrl_q;
  logic [DATA_W-1:0]   m_data_q, s_data_q;

  assign m_v      = state_q[1];
  assign s_v      = state_q[0];
  assign in_xfer  = In_Valid & ~s_v;
  assign out_xfer = m_v & Out_Ready;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state and capture enables; flush overrides every transfer
  always_comb begin
    state_d     = state_q;
    m_load_in   = 1'b0;
    m_load_skid = 1'b0;
    s_load_in   = 1'b0;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            m_load_in = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_load_in = 1'b1;
          end else if (in_xfer) begin
            s_load_in = 1'b1;
            state_d   = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (Out_Ready) begin
            m_load_skid = 1'b1;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Control payload: cleared on reset and flush, otherwise loaded on capture
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_ctrl_q <= '0;
      s_ctrl_q <= '0;
    end else if (Flush) begin
      m_ctrl_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      if (m_load_in)        m_ctrl_q <= Ctrl_In;
      else if (m_load_skid) m_ctrl_q <= s_ctrl_q;
      if (s_load_in)        s_ctrl_q <= Ctrl_In;
    end
  end

  // Data payload: loads only on capture, held through flush
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_data_q <= '0;
      s_data_q <= '0;
    end else begin
      if (m_load_in)        m_data_q <= Data_In;
      else if (m_load_skid) m_data_q <= s_data_q;
      if (s_load_in)        s_data_q <= Data_In;
    end
  end

  // Output decode; ctrl is masked whenever no beat is presented
  always_comb begin
    In_Ready  = ~s_v;
    Out_Valid = m_v;
    Ctrl_Out  = m_v ? m_ctrl_q : '0;
    Data_Out  = m_data_q;
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

  // Saturating stall/bubble counters; cleared by reset only
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (m_v && !Out_Ready && (stall_cnt_q != '1))  stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (!m_v && Out_Ready && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign Stall_Cnt  = stall_cnt_q;
  assign Bubble_Cnt = bubble_cnt_q;
`else
  assign Stall_Cnt  = '0;
  assign Bubble_Cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted beats are queued by the
// driver, a negedge monitor pops and compares every transferred output beat.
module tb_pipe_stage_reg;
  localparam int unsigned DATA_W = 224;
  localparam int unsigned CTRL_W = 9;
  localparam int unsigned CNT_W  = 16;

  logic              Clock = 1'b0;
  logic              Reset, Flush, In_Valid, Out_Ready;
  logic              In_Ready, Out_Valid;
  logic [CTRL_W-1:0] Ctrl_In, Ctrl_Out;
  logic [DATA_W-1:0] Data_In, Data_Out;
  logic [CNT_W-1:0]  Stall_Cnt, Bubble_Cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [CTRL_W+DATA_W-1:0] sb[$];

  always #5 Clock = ~Clock;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .Ctrl_In(Ctrl_In), .Data_In(Data_In),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Ctrl_Out(Ctrl_Out), .Data_Out(Data_Out),
    .Stall_Cnt(Stall_Cnt), .Bubble_Cnt(Bubble_Cnt)
  );

`ifdef PIPE_STAGE_STATS_EN
  logic              s_in_ready, s_out_valid;
  logic [CTRL_W-1:0] s_ctrl_out;
  logic [DATA_W-1:0] s_data_out;
  logic [1:0]        s_stall, s_bubble;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(2)) u_sat (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(s_in_ready), .Ctrl_In(Ctrl_In), .Data_In(Data_In),
    .Out_Valid(s_out_valid), .Out_Ready(Out_Ready), .Ctrl_Out(s_ctrl_out), .Data_Out(s_data_out),
    .Stall_Cnt(s_stall), .Bubble_Cnt(s_bubble)
  );
`endif

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one beat, holding it until accepted; queue it on acceptance
  task automatic send(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    bit done = 1'b0;
    In_Valid = 1'b1;
    Ctrl_In  = c;
    Data_In  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge Clock);
      if (In_Ready && !Flush) begin
        sb.push_back({c, d});
        done = 1'b1;
      end
      @(posedge Clock);
      #1;
    end
    In_Valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  // Monitor: compares every transferred beat and the bubble ctrl squash
  always @(negedge Clock) begin
    if (!Reset) begin
      if (!Out_Valid) chk("bubble_ctrl_zero", Ctrl_Out, 0);
      if (Out_Valid && Out_Ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", Data_Out, 256'h0BAD);
        end else begin
          logic [CTRL_W+DATA_W-1:0] e;
          e = sb.pop_front();
          chk("out_ctrl", Ctrl_Out, e[DATA_W +: CTRL_W]);
          chk("out_data", Data_Out, e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
    Ctrl_In = '0; Data_In = '0;
    #12;
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_ctrl_out",  Ctrl_Out, 0);
    chk("rst_data_out",  Data_Out, 0);
    chk("rst_in_ready",  In_Ready, 1);
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Streaming: one beat per cycle, one cycle latency
    Out_Ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stream_in_ready", In_Ready, 1);
      send(9'h100 | CTRL_W'(i), DATA_W'(i));
      chk("stream_latency_valid", Out_Valid, 1);
      chk("stream_latency_data", Data_Out, i);
    end

    // Bubbles: ctrl squashed, data holds the last beat
    @(posedge Clock); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("bubble_valid", Out_Valid, 0);
      chk("bubble_ctrl", Ctrl_Out, 0);
      chk("bubble_data_hold", Data_Out, 9);
    end

    // Back-pressure: A in main, B in skid, C held upstream
    @(posedge Clock); #1;
    Out_Ready = 1'b0;
    send(9'h0A1, 'hA);
    send(9'h0B2, 'hB);
    chk("bp_in_ready_low", In_Ready, 0);
    chk("bp_main_is_a", Data_Out, 'hA);
    fork
      send(9'h0C3, 'hC);
      begin
        repeat (3) @(posedge Clock);
        #1 Out_Ready = 1'b1;
      end
    join
    repeat (4) @(posedge Clock);
    #1;
    chk("bp_drained", sb.size(), 0);

    // Flush in FULL with a beat offered upstream
    Out_Ready = 1'b0;
    send(9'h1F0, 'h111);
    send(9'h1F1, 'h222);
    Flush = 1'b1; In_Valid = 1'b1; Ctrl_In = 9'h1FF; Data_In = 'hDEAD;
    @(posedge Clock); #1;
    Flush = 1'b0; In_Valid = 1'b0;
    sb.delete();
    chk("flush_valid", Out_Valid, 0);
    chk("flush_ctrl", Ctrl_Out, 0);
    chk("flush_data_hold", Data_Out, 'h111);
    chk("flush_in_ready", In_Ready, 1);
    Out_Ready = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
    chk("flush_stays_empty", Out_Valid, 0);

    // Flush in ONE with simultaneous input and output transfer
    Out_Ready = 1'b0;
    send(9'h033, 'h333);
    Out_Ready = 1'b1; Flush = 1'b1; In_Valid = 1'b1; Data_In = 'hDEAD;
    @(posedge Clock); #1;
    Flush = 1'b0; In_Valid = 1'b0;
    chk("flush_out_xfer_seen", sb.size(), 0);
    chk("flush_one_valid", Out_Valid, 0);
    chk("flush_one_data_hold", Data_Out, 'h333);
    repeat (3) @(posedge Clock);
    #1;

`ifndef PIPE_STAGE_STATS_EN
    chk("stats_off_stall", Stall_Cnt, 0);
    chk("stats_off_bubble", Bubble_Cnt, 0);
`endif

    // Asynchronous reset while FULL
    Out_Ready = 1'b0;
    send(9'h1FF, 'hAAA);
    send(9'h1FF, 'hBBB);
    chk("pre_rst_full", In_Ready, 0);
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_valid", Out_Valid, 0);
    chk("async_rst_ctrl", Ctrl_Out, 0);
    chk("async_rst_data", Data_Out, 0);
    chk("async_rst_in_ready", In_Ready, 1);
    chk("async_rst_stall", Stall_Cnt, 0);
    sb.delete();
    @(posedge Clock); #1;
    Reset = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
    Out_Ready = 1'b1;
    repeat (3) @(posedge Clock);
    #1 Out_Ready = 1'b0;
    chk("stats_bubble3", Bubble_Cnt, 3);
    send(9'h055, 'h555);
    repeat (5) @(posedge Clock);
    #1;
    chk("stats_stall5", Stall_Cnt, 5);
    chk("stats_bubble_still3", Bubble_Cnt, 3);
    @(posedge Clock); #1;
    chk("stats_sat_stall", s_stall, 3);
    chk("stats_stall6", Stall_Cnt, 6);
    Out_Ready = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field MEM/WB stage register.
- Provides one generic pipeline stage with valid/ready handshake, a 2-entry skid buffer so back-pressure does not cut the timing path, synchronous flush, and control-field squashing on bubbles.
- Instantiated between any two pipeline stages. Control bundle (e.g. RegWrite, L16B, MemToReg, RegDest) and data bundle (ALUResult, PC, ReadData, WD3_128) are carried as separate packed vectors.

Parameters:
- DATA_W, 224, width of data payload; not cleared on flush.
- CTRL_W, 9, width of control payload; zeroed on bubble, flush and reset.
- CNT_W, 16, width of stats counters (only used with PIPE_STAGE_STATS_EN).

Ports:
- Clock  input  1  stage clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Flush  input  1  synchronous squash of all held entries.
- In_Valid  input  1  upstream has a beat.
- In_Ready  output  1  stage can accept a beat.
- Ctrl_In  input  CTRL_W  control payload.
- Data_In  input  DATA_W  data payload.
- Out_Valid  output  1  stage presents a beat.
- Out_Ready  input  1  downstream accepts; Out_Ready=0 is a stall.
- Ctrl_Out  output  CTRL_W  control payload; forced 0 when Out_Valid=0.
- Data_Out  output  DATA_W  data payload; holds last value when Out_Valid=0.
- Stall_Cnt  output  CNT_W  stats only (see Optional Feature).
- Bubble_Cnt  output  CNT_W  stats only (see Optional Feature).

Behaviour:
- Storage: main entry {m_v, m_ctrl, m_data} and skid entry {s_v, s_ctrl, s_data}.
- Reset (async, any time including mid-transfer): m_v=s_v=0; all ctrl/data registers 0. Outputs at reset: Out_Valid=0, Ctrl_Out=0, Data_Out=0, In_Ready=1, counters 0.
- State encoding {m_v,s_v}: EMPTY=00, ONE=10, FULL=11. State 01 is illegal and never reached.
- In_Ready = !s_v (registered, no combinational path from Out_Ready).
- Out_Valid = m_v. Data_Out = m_data. Ctrl_Out = m_v ? m_ctrl : 0.
- Input transfer = In_Valid & In_Ready. Output transfer = m_v & Out_Ready.
- Transitions (no Flush):
  - EMPTY: input transfer -> main<=in, ONE. Otherwise stay.
  - ONE, in and out transfer -> main<=in, stay ONE.
  - ONE, in only -> skid<=in, FULL.
  - ONE, out only -> EMPTY.
  - ONE, neither -> hold.
  - FULL, Out_Ready=1 -> main<=skid, s_v=0, ONE.
  - FULL, Out_Ready=0 -> hold all.
- Latency: 1 cycle from accepted input to Out_Valid when empty. Throughput: 1 beat/cycle with Out_Ready held 1.
- Ordering is strictly FIFO; no beat is dropped or duplicated except by Flush.
- Flush=1: next cycle m_v=s_v=0, m_ctrl=s_ctrl=0, data registers held. Flush beats a simultaneous input transfer (the beat is discarded) and a simultaneous output transfer (downstream still sees that cycle's beat as transferred).
- Flush and Reset together: Reset wins.
- Data registers load only on the capture conditions above (no enable toggling otherwise), to save power.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined:
  - Stall_Cnt increments each cycle m_v & !Out_Ready.
  - Bubble_Cnt increments each cycle !m_v & Out_Ready.
  - Both saturate at all-ones, clear on Reset only (not on Flush).
- When undefined: both ports tie to 0 and no counter flops are generated.

Test Plan:
- Reset mid-stream: FULL with Ctrl_In=9'h1FF, assert Reset asynchronously -> Out_Valid=0, Ctrl_Out=0, Data_Out=0, In_Ready=1 immediately, without a clock edge.
- Streaming: Out_Ready=1, In_Valid=1, Data_In=0,1,2..9 on consecutive cycles -> Data_Out=0..9 one cycle later each, In_Ready stays 1.
- Back-pressure: stream A,B,C with Out_Ready=0 from the cycle A appears -> B goes to skid, In_Ready=0, C held upstream; release Out_Ready -> outputs A,B,C in order, no loss.
- Flush priority: FULL state, Flush=1 with In_Valid=1 and Data_In=0xDEAD -> next cycle Out_Valid=0, Ctrl_Out=0, 0xDEAD never appears on output.
- Bubble squash: In_Valid=0 for 3 cycles with Out_Ready=1 -> Ctrl_Out=0 (RegWrite low) each cycle while Data_Out holds its last value.
- Stats (PIPE_STAGE_STATS_EN): 5 stalled cycles and 3 empty cycles with Out_Ready=1 -> Stall_Cnt=5, Bubble_Cnt=3. With CNT_W=2, force 6 stalls -> Stall_Cnt saturates at 3.
